sc_row_scan_controller: RTL and testbench

Sequencer that walks the Frogger lane registers one row at a time and drives the row-select mux into the shared lane-register bank. It performs the all-zero ("row empty") check that the first-register comparator does for a single row. It also checks the frog's column mask against the frog's row for collision. It reports empty-row count, level-clear and collision to the game FSM through a start/done handshake.

---
 rtl/sc_row_scan_controller.sv | 159 +++++++++++++++
 tb/tb_sc_row_scan_controller.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/sc_row_scan_controller.sv
// sc_row_scan_controller
// Walks the lane-register bank one row at a time through the row-select mux.
// For each row it counts all-zero rows and tests the frog's latched column
// mask against the frog's latched row. The game FSM gets the results through
// a start/done handshake.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// IDLE    | waiting for start; results of the last scan held stable
// SEL     | rowsel stable while the bank performs its 1-cycle registered read
// CMP     | rowdata valid for rowsel: count empty row, test frog collision
// DONE    | one-cycle done pulse; rowsel returns to 0 on leaving
//
// Each row costs two cycles (SEL + CMP). The bank's read latency is fixed at
// one cycle, so CMP always sees the data for the rowsel value set before SEL.

module sc_row_scan_controller #(
    parameter int ROWSCAN_DATAWIDTH   = 8,
    parameter int ROWSCAN_NUMROWS     = 8,
    parameter int ROWSCAN_ROWSELWIDTH = 3
) (
    input  logic                           SC_ROWSCAN_CLOCK_50,
    input  logic                           SC_ROWSCAN_RESET_InLow,
    input  logic                           SC_ROWSCAN_start_InHigh,
    input  logic [ROWSCAN_DATAWIDTH-1:0]   SC_ROWSCAN_rowdata_InBUS,
    input  logic [ROWSCAN_ROWSELWIDTH-1:0] SC_ROWSCAN_frogrow_InBUS,
    input  logic [ROWSCAN_DATAWIDTH-1:0]   SC_ROWSCAN_frogmask_InBUS,
    output logic [ROWSCAN_ROWSELWIDTH-1:0] SC_ROWSCAN_rowsel_OutBUS,
    output logic                           SC_ROWSCAN_busy_OutHigh,
    output logic                           SC_ROWSCAN_done_OutHigh,
    output logic [ROWSCAN_ROWSELWIDTH:0]   SC_ROWSCAN_emptycount_OutBUS,
    output logic                           SC_ROWSCAN_levelclear_OutHigh,
    output logic                           SC_ROWSCAN_collision_OutHigh
);

    localparam int RSW = ROWSCAN_ROWSELWIDTH;
    localparam int DW  = ROWSCAN_DATAWIDTH;

    // Last row index; the scan ends after this row's compare.
    localparam logic [RSW-1:0] LAST_ROW   = RSW'(ROWSCAN_NUMROWS - 1);
    // emptycount value meaning every scanned row was empty.
    localparam logic [RSW:0]   FULL_COUNT = (RSW + 1)'(ROWSCAN_NUMROWS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEL  = 2'd1,
        ST_CMP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t          state_q,      state_d;
    logic [RSW-1:0]  rowsel_q,     rowsel_d;
    logic            busy_q,       busy_d;
    logic            done_q,       done_d;
    logic [RSW:0]    emptycount_q, emptycount_d;
    logic            collision_q,  collision_d;
    logic [RSW-1:0]  frogrow_q,    frogrow_d;
    logic [DW-1:0]   frogmask_q,   frogmask_d;

    logic            row_is_empty;
    logic            row_is_frog;
    logic            frog_hit;

    // Per-row compare terms used in CMP.
    always_comb begin
        row_is_empty = (SC_ROWSCAN_rowdata_InBUS == '0);
        row_is_frog  = (rowsel_q == frogrow_q);
        frog_hit     = row_is_frog && ((SC_ROWSCAN_rowdata_InBUS & frogmask_q) != '0);
    end

    // Next-state and next-output decode; busy/done follow the next state so
    // they are registered Moore outputs aligned with the state register.
    always_comb begin
        state_d      = state_q;
        rowsel_d     = rowsel_q;
        emptycount_d = emptycount_q;
        collision_d  = collision_q;
        frogrow_d    = frogrow_q;
        frogmask_d   = frogmask_q;

        case (state_q)
            ST_IDLE: begin
                if (SC_ROWSCAN_start_InHigh) begin
                    state_d      = ST_SEL;
                    rowsel_d     = '0;
                    emptycount_d = '0;
                    collision_d  = 1'b0;
                    frogrow_d    = SC_ROWSCAN_frogrow_InBUS;
                    frogmask_d   = SC_ROWSCAN_frogmask_InBUS;
                end
            end
            ST_SEL: begin
                state_d = ST_CMP;
            end
            ST_CMP: begin
                if (row_is_empty) begin
                    emptycount_d = emptycount_q + 1'b1;
                end
                // Collision is sticky for the rest of the scan.
                if (frog_hit) begin
                    collision_d = 1'b1;
                end
                if (rowsel_q == LAST_ROW) begin
                    state_d = ST_DONE;
                end else begin
                    rowsel_d = rowsel_q + 1'b1;
                    state_d  = ST_SEL;
                end
            end
            ST_DONE: begin
                state_d  = ST_IDLE;
                rowsel_d = '0;
            end
            default: begin
                state_d  = ST_IDLE;
                rowsel_d = '0;
            end
        endcase

        busy_d = (state_d == ST_SEL) || (state_d == ST_CMP);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers; reset aborts any scan without a done pulse.
    always_ff @(posedge SC_ROWSCAN_CLOCK_50 or negedge SC_ROWSCAN_RESET_InLow) begin
        if (!SC_ROWSCAN_RESET_InLow) begin
            state_q      <= ST_IDLE;
            rowsel_q     <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            emptycount_q <= '0;
            collision_q  <= 1'b0;
            frogrow_q    <= '0;
            frogmask_q   <= '0;
        end else begin
            state_q      <= state_d;
            rowsel_q     <= rowsel_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            emptycount_q <= emptycount_d;
            collision_q  <= collision_d;
            frogrow_q    <= frogrow_d;
            frogmask_q   <= frogmask_d;
        end
    end

    // Level clear is a decode of the registered count, so it is valid from
    // the done cycle and holds with the count while idle.
    always_comb begin
        SC_ROWSCAN_levelclear_OutHigh = (emptycount_q == FULL_COUNT);
    end

    assign SC_ROWSCAN_rowsel_OutBUS     = rowsel_q;
    assign SC_ROWSCAN_busy_OutHigh      = busy_q;
    assign SC_ROWSCAN_done_OutHigh      = done_q;
    assign SC_ROWSCAN_emptycount_OutBUS = emptycount_q;
    assign SC_ROWSCAN_collision_OutHigh = collision_q;

endmodule

// File: tb/tb_sc_row_scan_controller.sv
// Testbench for sc_row_scan_controller: table of directed scan vectors plus
// hand-written sequences for held start, mid-scan start, reset abort,
// back-to-back start and idle result hold.

module tb_sc_row_scan_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] rowdata;
    logic [2:0] frogrow;
    logic [7:0] frogmask;
    logic [2:0] rowsel;
    logic       busy;
    logic       done;
    logic [3:0] emptycount;
    logic       levelclear;
    logic       collision;

    int n_checks = 0;
    int n_fail   = 0;

    // Lane-register bank model: registered read, data one cycle after rowsel.
    logic [7:0] bank [8];

    sc_row_scan_controller dut (
        .SC_ROWSCAN_CLOCK_50          (clk),
        .SC_ROWSCAN_RESET_InLow       (rst_n),
        .SC_ROWSCAN_start_InHigh      (start),
        .SC_ROWSCAN_rowdata_InBUS     (rowdata),
        .SC_ROWSCAN_frogrow_InBUS     (frogrow),
        .SC_ROWSCAN_frogmask_InBUS    (frogmask),
        .SC_ROWSCAN_rowsel_OutBUS     (rowsel),
        .SC_ROWSCAN_busy_OutHigh      (busy),
        .SC_ROWSCAN_done_OutHigh      (done),
        .SC_ROWSCAN_emptycount_OutBUS (emptycount),
        .SC_ROWSCAN_levelclear_OutHigh(levelclear),
        .SC_ROWSCAN_collision_OutHigh (collision)
    );

    always #10 clk = ~clk;

    always @(posedge clk) rowdata <= bank[rowsel];

    typedef struct packed {
        logic [63:0] rows;      // row i in bits [8*i +: 8]
        logic [2:0]  frow;
        logic [7:0]  fmask;
        logic [3:0]  exp_empty;
        logic        exp_level;
        logic        exp_coll;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < 8; i++) bank[i] = v.rows[8*i +: 8];
        frogrow  = v.frow;
        frogmask = v.fmask;
    endtask

    // Full scan with per-cycle rowsel/busy/done checks. mid_m >= 0 pulses
    // start with altered frog inputs in that cycle of the scan.
    task automatic run_scan(input vec_t v, input int mid_m, input string tag);
        int exp_sel;
        @(negedge clk);
        load_vec(v);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int m = 0; m <= 16; m++) begin
            exp_sel = (m / 2 > 7) ? 7 : m / 2;
            chk({tag, "_rowsel"}, 32'(rowsel), 32'(exp_sel));
            chk({tag, "_busy"},   32'(busy),   32'(m < 16));
            chk({tag, "_done"},   32'(done),   32'(m == 16));
            if (m == mid_m) begin
                start    = 1'b1;
                frogrow  = ~v.frow;
                frogmask = ~v.fmask;
            end else if (m == mid_m + 1) begin
                start    = 1'b0;
                frogrow  = v.frow;
                frogmask = v.fmask;
            end
            if (m < 16) begin
                @(posedge clk); #1;
            end
        end
        chk({tag, "_emptycount"}, 32'(emptycount), 32'(v.exp_empty));
        chk({tag, "_levelclear"}, 32'(levelclear), 32'(v.exp_level));
        chk({tag, "_collision"},  32'(collision),  32'(v.exp_coll));
        @(posedge clk); #1;
        chk({tag, "_post_done"},   32'(done),   32'd0);
        chk({tag, "_post_rowsel"}, 32'(rowsel), 32'd0);
        chk({tag, "_post_busy"},   32'(busy),   32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int dones;
        int w;

        //              rows (7..0)               frow  fmask  empty lvl coll
        vecs[0] = '{64'h0000_0000_0000_0000, 3'd0, 8'h01, 4'd8, 1'b1, 1'b0};
        vecs[1] = '{64'hFF00_0081_003C_0000, 3'd0, 8'h01, 4'd5, 1'b0, 1'b0};
        vecs[2] = '{64'h0000_0000_1800_0000, 3'd3, 8'h10, 4'd7, 1'b0, 1'b1};
        vecs[3] = '{64'h0000_0000_0800_0000, 3'd3, 8'h10, 4'd7, 1'b0, 1'b0};
        vecs[4] = '{64'h0000_1000_0000_0000, 3'd3, 8'h10, 4'd7, 1'b0, 1'b0};
        vecs[5] = '{64'hFF00_0000_0000_0000, 3'd7, 8'h80, 4'd7, 1'b0, 1'b1};
        vecs[6] = '{64'hFFFF_FFFF_FFFF_FFFF, 3'd0, 8'h01, 4'd0, 1'b0, 1'b1};
        vecs[7] = '{64'h0000_0000_0100_0000, 3'd3, 8'h01, 4'd7, 1'b0, 1'b1};

        rst_n    = 1'b0;
        start    = 1'b0;
        frogrow  = '0;
        frogmask = '0;
        rowdata  = '0;
        for (int i = 0; i < 8; i++) bank[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_rowsel",     32'(rowsel),     32'd0);
        chk("reset_busy",       32'(busy),       32'd0);
        chk("reset_done",       32'(done),       32'd0);
        chk("reset_emptycount", 32'(emptycount), 32'd0);
        chk("reset_levelclear", 32'(levelclear), 32'd0);
        chk("reset_collision",  32'(collision),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int v = 0; v < 8; v++) begin
            run_scan(vecs[v], -1, $sformatf("vec%0d", v));
        end

        // Results hold while idle even as inputs wander.
        run_scan(vecs[1], -1, "hold");
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            for (int i = 0; i < 8; i++) bank[i] = 8'($urandom_range(0, 255));
            frogrow  = 3'($urandom_range(0, 7));
            frogmask = 8'($urandom_range(0, 255));
            @(posedge clk); #1;
            chk("hold_emptycount", 32'(emptycount), 32'd5);
            chk("hold_levelclear", 32'(levelclear), 32'd0);
            chk("hold_collision",  32'(collision),  32'd0);
            chk("hold_done",       32'(done),       32'd0);
        end

        // Mid-scan start with different frog row/mask is ignored.
        run_scan(vecs[2], 6, "midstart");

        // Start held high: one done per scan period, no extras.
        @(negedge clk);
        load_vec(vecs[0]);
        start = 1'b1;
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        start = 1'b0;
        chk("held_start_dones", 32'(dones), 32'd2);
        repeat (20) @(posedge clk);
        #1;
        chk("held_start_idle", 32'(busy), 32'd0);

        // Reset during CMP of row 4 aborts with no done.
        @(negedge clk);
        load_vec(vecs[1]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("abort_pre_rowsel", 32'(rowsel), 32'd4);
        chk("abort_pre_busy",   32'(busy),   32'd1);
        #4;
        rst_n = 1'b0;
        #1;
        chk("abort_rowsel",     32'(rowsel),     32'd0);
        chk("abort_busy",       32'(busy),       32'd0);
        chk("abort_done",       32'(done),       32'd0);
        chk("abort_emptycount", 32'(emptycount), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        chk("abort_no_done", 32'(dones), 32'd0);
        run_scan(vecs[0], -1, "after_abort");

        // Start in the cycle right after done is accepted and clears results.
        run_scan(vecs[2], -1, "b2b_first");
        load_vec(vecs[0]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        chk("b2b_emptycount_clr", 32'(emptycount), 32'd0);
        chk("b2b_collision_clr",  32'(collision),  32'd0);
        chk("b2b_busy",           32'(busy),       32'd1);
        w = 0;
        while (!done && w < 40) begin
            @(posedge clk); #1;
            w++;
        end
        chk("b2b_done_latency", 32'(w),          32'd16);
        chk("b2b_emptycount",   32'(emptycount), 32'd8);
        chk("b2b_levelclear",   32'(levelclear), 32'd1);
        chk("b2b_collision",    32'(collision),  32'd0);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
